// File: rtl/bullet_pkg.sv
// Shared constants and slot-state encodings for the multi-bullet controller.
package bullet_pkg;

   localparam int DEFAULT_NUM_BULLETS     = 4;
   localparam int DEFAULT_COOLDOWN_FRAMES = 8;
   localparam int COOLDOWN_W              = 8;

   typedef enum logic [1:0] {
      SLOT_IDLE   = 2'd0,
      SLOT_LAUNCH = 2'd1,
      SLOT_WAIT   = 2'd2,
      SLOT_UPDATE = 2'd3
   } slot_state_e;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_UPDATE = 2'd3;

endpackage

// File: rtl/bullet_slot_fsm.sv
// One bullet slot: idle until granted, one launch cycle, then waits/moves on frame
// ticks until it reaches the top or hits an enemy.
module bullet_slot_fsm
   import bullet_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic grant,
   input  logic tick,
   input  logic top,
   input  logic hit,
   output logic in_reset,
   output logic in_update,
   output logic launch_pulse
);

   logic [1:0] state_q;
   logic [1:0] state_d;
   logic       kill;

   assign kill = top | hit;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (grant) state_d = ST_LAUNCH;
         ST_LAUNCH: state_d = ST_WAIT;
         // a kill in the same cycle as a tick retires the bullet without a move strobe
         ST_WAIT: begin
            if (kill)      state_d = ST_IDLE;
            else if (tick) state_d = ST_UPDATE;
         end
         ST_UPDATE: state_d = kill ? ST_IDLE : ST_WAIT;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   assign in_reset     = (state_q == ST_IDLE);
   assign in_update    = (state_q == ST_UPDATE);
   assign launch_pulse = (state_q == ST_LAUNCH);

endmodule

// File: rtl/multi_bullet_control.sv
// Fire-request edge detect, cooldown, lowest-index slot allocator and per-slot FSMs.
// Define BULLET_AUTOFIRE_EN to fire on the held key level instead of its rising edge.
module multi_bullet_control
   import bullet_pkg::*;
#(
   parameter int NUM_BULLETS     = DEFAULT_NUM_BULLETS,
   parameter int COOLDOWN_FRAMES = DEFAULT_COOLDOWN_FRAMES
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               spacePressed,
   input  logic                               updatePosition,
   input  logic [NUM_BULLETS-1:0]             topReached,
   input  logic [NUM_BULLETS-1:0]             collidedWithEnemy,
   output logic [NUM_BULLETS-1:0]             inResetState,
   output logic [NUM_BULLETS-1:0]             inUpdatePositionState,
   output logic [NUM_BULLETS-1:0]             launchPulse,
   output logic [$clog2(NUM_BULLETS+1)-1:0]   activeCount
);

   localparam int CNT_W = $clog2(NUM_BULLETS + 1);

   logic                   space_q;
   logic                   space_d;
   logic [COOLDOWN_W-1:0]  cooldown_q;
   logic [COOLDOWN_W-1:0]  cooldown_d;
   logic                   cooldown_zero;
   logic                   fire_req;
   logic                   idle_found;
   logic                   grant_any;
   logic [NUM_BULLETS-1:0] grant_vec;
   logic [CNT_W-1:0]       active_cnt;

   assign cooldown_zero = (cooldown_q == '0);
   assign space_d       = spacePressed;

`ifdef BULLET_AUTOFIRE_EN
   assign fire_req = spacePressed & cooldown_zero;
`else
   assign fire_req = spacePressed & ~space_q & cooldown_zero;
`endif

   // Allocation looks at registered state, so a slot freed this cycle waits one cycle.
   always_comb begin
      grant_vec  = '0;
      idle_found = 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
         if (!idle_found && inResetState[i]) begin
            grant_vec[i] = fire_req;
            idle_found   = 1'b1;
         end
      end
   end

   assign grant_any = fire_req & idle_found;

   always_comb begin
      cooldown_d = cooldown_q;
      if (grant_any)
         cooldown_d = COOLDOWN_W'(COOLDOWN_FRAMES);
      else if (updatePosition && !cooldown_zero)
         cooldown_d = cooldown_q - COOLDOWN_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         space_q    <= 1'b0;
         cooldown_q <= '0;
      end else begin
         space_q    <= space_d;
         cooldown_q <= cooldown_d;
      end
   end

   for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
      bullet_slot_fsm u_slot (
         .clk          (clk),
         .reset        (reset),
         .grant        (grant_vec[i]),
         .tick         (updatePosition),
         .top          (topReached[i]),
         .hit          (collidedWithEnemy[i]),
         .in_reset     (inResetState[i]),
         .in_update    (inUpdatePositionState[i]),
         .launch_pulse (launchPulse[i])
      );
   end

   always_comb begin
      active_cnt = '0;
      for (int i = 0; i < NUM_BULLETS; i++)
         active_cnt = active_cnt + CNT_W'(!inResetState[i]);
   end

   assign activeCount = active_cnt;

endmodule

// File: tb/tb_multi_bullet_control.sv
// Self-checking bench for multi_bullet_control with a slot/cooldown reference model.
module tb_multi_bullet_control;

   localparam int N = 4;
`ifdef BULLET_AUTOFIRE_EN
   localparam int TB_CD = 3;
`else
   localparam int TB_CD = 2;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         spacePressed = 1'b0;
   logic         updatePosition = 1'b0;
   logic [N-1:0] topReached = '0;
   logic [N-1:0] collidedWithEnemy = '0;
   logic [N-1:0] inResetState;
   logic [N-1:0] inUpdatePositionState;
   logic [N-1:0] launchPulse;
   logic [2:0]   activeCount;

   int checks = 0;
   int failures = 0;

   multi_bullet_control #(.NUM_BULLETS(N), .COOLDOWN_FRAMES(TB_CD)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .spacePressed          (spacePressed),
      .updatePosition        (updatePosition),
      .topReached            (topReached),
      .collidedWithEnemy     (collidedWithEnemy),
      .inResetState          (inResetState),
      .inUpdatePositionState (inUpdatePositionState),
      .launchPulse           (launchPulse),
      .activeCount           (activeCount)
   );

   always #5 clk = ~clk;

   // Reference model: each bullet is alive or not; a live one is either just launched,
   // moving this cycle, or parked between frames.
   bit m_alive[N];
   bit m_launch[N];
   bit m_move[N];
   int m_cd;
   bit m_prev;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_alive[i] = 0; m_launch[i] = 0; m_move[i] = 0;
      end
      m_cd = 0;
      m_prev = 0;
   endfunction

   function automatic void model_update(input bit sp, input bit tk, input bit [N-1:0] tp, input bit [N-1:0] ht);
      bit req;
      int g;
      bit na[N], nl[N], nm[N];
`ifdef BULLET_AUTOFIRE_EN
      req = sp;
`else
      req = sp && !m_prev;
`endif
      req = req && (m_cd == 0);
      g = -1;
      if (req)
         for (int i = 0; i < N; i++)
            if (g < 0 && !m_alive[i]) g = i;
      for (int i = 0; i < N; i++) begin
         na[i] = m_alive[i]; nl[i] = 0; nm[i] = 0;
         if (!m_alive[i]) begin
            if (i == g) begin na[i] = 1; nl[i] = 1; end
         end else if (m_launch[i]) begin
            na[i] = 1;
         end else if (tp[i] || ht[i]) begin
            na[i] = 0;
         end else if (!m_move[i] && tk) begin
            nm[i] = 1;
         end
      end
      for (int i = 0; i < N; i++) begin
         m_alive[i] = na[i]; m_launch[i] = nl[i]; m_move[i] = nm[i];
      end
      if (g >= 0) m_cd = TB_CD;
      else if (tk && m_cd > 0) m_cd = m_cd - 1;
      m_prev = sp;
   endfunction

   function automatic logic [N-1:0] exp_idle();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = !m_alive[i];
      return r;
   endfunction

   function automatic logic [N-1:0] exp_move();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = m_move[i];
      return r;
   endfunction

   function automatic logic [N-1:0] exp_pulse();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = m_launch[i];
      return r;
   endfunction

   function automatic logic [2:0] exp_count();
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(m_alive[i]);
      return 3'(c);
   endfunction

   // Called at a falling edge; applies inputs for one cycle and returns at the next falling edge.
   task automatic step(input logic sp, input logic tk, input logic [N-1:0] tp, input logic [N-1:0] ht);
      spacePressed = sp;
      updatePosition = tk;
      topReached = tp;
      collidedWithEnemy = ht;
      model_update(sp, tk, tp, ht);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      spacePressed = 1'b0;
      updatePosition = 1'b0;
      topReached = '0;
      collidedWithEnemy = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic launch_slot();
      step(1'b1, 1'b0, '0, '0);
      for (int k = 0; k < TB_CD; k++) step(1'b0, 1'b1, '0, '0);
   endtask

   task automatic test_reset();
      @(negedge clk);
      #1;
      checks++;
      if (inResetState !== 4'b1111) begin failures++; $display("FAIL reset_idle: got %b expected 1111", inResetState); end
      checks++;
      if ({inUpdatePositionState, launchPulse, activeCount} !== 11'd0) begin failures++; $display("FAIL reset_outputs: upd=%b pulse=%b cnt=%0d expected all zero", inUpdatePositionState, launchPulse, activeCount); end
      do_reset();
      step(1'b0, 1'b1, '0, '0);
      checks++;
      if (inResetState !== 4'b1111 || activeCount !== 3'd0) begin failures++; $display("FAIL post_reset_idle: idle=%b cnt=%0d expected 1111/0", inResetState, activeCount); end
   endtask

   task automatic test_cooldown();
      do_reset();
      step(1'b1, 1'b0, '0, '0);
      checks++;
      if (launchPulse !== 4'b0001) begin failures++; $display("FAIL cd_first_launch: got %b expected 0001", launchPulse); end
      step(1'b0, 1'b1, '0, '0);
      checks++;
      if (launchPulse !== 4'b0000) begin failures++; $display("FAIL cd_pulse_one_cycle: got %b expected 0000", launchPulse); end
      step(1'b1, 1'b0, '0, '0);
      checks++;
      if (launchPulse !== 4'b0000) begin failures++; $display("FAIL cd_blocked: got %b expected 0000", launchPulse); end
      step(1'b0, 1'b1, '0, '0);
      step(1'b1, 1'b0, '0, '0);
      checks++;
      if (launchPulse !== 4'b0010) begin failures++; $display("FAIL cd_second_launch: got %b expected 0010", launchPulse); end
      step(1'b1, 1'b0, '0, '0);
      checks++;
      if (launchPulse !== 4'b0000) begin failures++; $display("FAIL held_key_once: got %b expected 0000", launchPulse); end
   endtask

   task automatic test_full();
      do_reset();
      for (int k = 0; k < N; k++) begin
         step(1'b1, 1'b0, '0, '0);
         checks++;
         if (launchPulse !== 4'(1 << k)) begin failures++; $display("FAIL fill_order_%0d: got %b expected %b", k, launchPulse, 4'(1 << k)); end
         for (int t = 0; t < TB_CD; t++) step(1'b0, 1'b1, '0, '0);
      end
      step(1'b1, 1'b0, '0, '0);
      checks++;
      if (launchPulse !== 4'b0000 || activeCount !== 3'd4) begin failures++; $display("FAIL full_drop: pulse=%b cnt=%0d expected 0000/4", launchPulse, activeCount); end
      step(1'b0, 1'b0, '0, 4'b1000);
      checks++;
      if (inResetState !== 4'b1000 || activeCount !== 3'd3) begin failures++; $display("FAIL kill_wait: idle=%b cnt=%0d expected 1000/3", inResetState, activeCount); end
      step(1'b1, 1'b0, '0, '0);
      checks++;
      if (launchPulse !== 4'b1000) begin failures++; $display("FAIL no_cd_after_drop: got %b expected 1000", launchPulse); end
   endtask

   task automatic test_update_kill();
      do_reset();
      launch_slot();
      launch_slot();
      step(1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b1, '0, '0);
      checks++;
      if (inUpdatePositionState !== 4'b0011) begin failures++; $display("FAIL update_strobe: got %b expected 0011", inUpdatePositionState); end
      step(1'b0, 1'b0, 4'b0010, 4'b0010);
      checks++;
      if (inResetState !== 4'b1110 || inUpdatePositionState !== 4'b0000 || activeCount !== 3'd1) begin failures++; $display("FAIL update_kill: idle=%b upd=%b cnt=%0d expected 1110/0000/1", inResetState, inUpdatePositionState, activeCount); end
   endtask

   task automatic test_wait_kill_tick();
      do_reset();
      launch_slot();
      launch_slot();
      launch_slot();
      step(1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b1, '0, 4'b0100);
      checks++;
      if (inResetState !== 4'b1100 || inUpdatePositionState !== 4'b0011) begin failures++; $display("FAIL kill_beats_tick: idle=%b upd=%b expected 1100/0011", inResetState, inUpdatePositionState); end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      launch_slot();
      launch_slot();
      launch_slot();
      step(1'b0, 1'b0, '0, '0);
      checks++;
      if (activeCount !== 3'd3) begin failures++; $display("FAIL midflight_setup: got %0d expected 3", activeCount); end
      reset = 1'b1;
      model_reset();
      #1;
      checks++;
      if (inResetState !== 4'b1111 || activeCount !== 3'd0 || launchPulse !== 4'b0000) begin failures++; $display("FAIL async_reset: idle=%b cnt=%0d pulse=%b expected 1111/0/0000", inResetState, activeCount, launchPulse); end
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (inResetState !== 4'b1111 || activeCount !== 3'd0) begin failures++; $display("FAIL reset_next_cycle: idle=%b cnt=%0d expected 1111/0", inResetState, activeCount); end
      step(1'b1, 1'b0, '0, '0);
      checks++;
      if (launchPulse !== 4'b0001) begin failures++; $display("FAIL grant_after_reset: got %b expected 0001", launchPulse); end
   endtask

   task automatic test_autofire();
      int order[$];
      do_reset();
      for (int c = 0; c < 48; c++) begin
         step(1'b1, (c % 4) == 3, '0, '0);
         checks++;
         if (launchPulse !== exp_pulse()) begin failures++; $display("FAIL autofire_pulse c=%0d: got %b expected %b", c, launchPulse, exp_pulse()); end
         for (int i = 0; i < N; i++) if (launchPulse[i]) order.push_back(i);
      end
      checks++;
      if (order.size() != 4) begin failures++; $display("FAIL autofire_count: got %0d expected 4", order.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (order[i] != i) begin failures++; $display("FAIL autofire_order_%0d: got slot %0d expected slot %0d", i, order[i], i); end
         end
      end
   endtask

   task automatic test_random();
      logic sp;
      logic [N-1:0] tp, ht;
      do_reset();
      sp = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 2) == 0) sp = ~sp;
         tp = 4'($urandom) & 4'($urandom) & 4'($urandom);
         ht = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
         step(sp, $urandom_range(0, 3) == 0, tp, ht);
         checks++;
         if (inResetState !== exp_idle() || inUpdatePositionState !== exp_move() ||
             launchPulse !== exp_pulse() || activeCount !== exp_count()) begin
            failures++;
            $display("FAIL random c=%0d: idle=%b upd=%b pulse=%b cnt=%0d expected idle=%b upd=%b pulse=%b cnt=%0d",
                     c, inResetState, inUpdatePositionState, launchPulse, activeCount,
                     exp_idle(), exp_move(), exp_pulse(), exp_count());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
`ifdef BULLET_AUTOFIRE_EN
      test_autofire();
`else
      test_cooldown();
      test_full();
      test_update_kill();
      test_wait_kill_tick();
      test_reset_midflight();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
